pipe_control_unit: RTL

Pipelined main control unit for the 5-stage RV32I core; successor to the combinational opcode decoder. Decodes the ID-stage opcode and registers the control word through the ID/EX, EX/MEM and MEM/WB stages. Detects load-use hazards and applies stall, flush and hold sequencing. Drives PC/IF-ID enables and exposes per-stage control to the datapath.

---
 rtl/pipe_control_unit.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_control_unit.sv
// Pipelined main control unit for a 5-stage RV32I core.
// Decodes the ID opcode, carries the control word through ID/EX, EX/MEM and
// MEM/WB, and sequences stall / flush / hold for the front end.
module pipe_control_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int ALUOP_W     = 2,
  parameter int ENABLE_JUMP = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            idOpcode,
  input  logic [REG_ADDR_W-1:0] idRs1,
  input  logic [REG_ADDR_W-1:0] idRs2,
  input  logic [REG_ADDR_W-1:0] idRd,
  input  logic                  flush,
  input  logic                  hold,
  output logic                  pcWrite,
  output logic                  ifidWrite,
  output logic                  ifidFlush,
  output logic [ALUOP_W-1:0]    exALUop,
  output logic                  exALUsrc,
  output logic                  exBranch,
  output logic [1:0]            exJump,
  output logic                  exMemRead,
  output logic [REG_ADDR_W-1:0] exRd,
  output logic                  memMemRead,
  output logic                  memMemWrite,
  output logic [REG_ADDR_W-1:0] memRd,
  output logic                  wbRegWrite,
  output logic                  wbMemtoReg,
  output logic [REG_ADDR_W-1:0] wbRd,
  output logic                  exIllegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BUBBLE = 7'b0000000;
  localparam bit         JUMP_EN   = (ENABLE_JUMP != 0);

  typedef struct packed {
    logic [ALUOP_W-1:0]    alu_op;
    logic                  alu_src;
    logic                  branch;
    logic [1:0]            jump;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic                  illegal;
    logic [REG_ADDR_W-1:0] rd;
  } ctrl_t;

  ctrl_t                 dec;
  logic                  uses_rs1;
  logic                  uses_rs2;
  logic                  load_use;

  ctrl_t                 id_ex_d, id_ex_q;
  logic                  ex_mem_read_d, ex_mem_read_q;
  logic                  ex_mem_write_d, ex_mem_write_q;
  logic                  ex_mem_to_reg_d, ex_mem_to_reg_q;
  logic                  ex_mem_reg_write_d, ex_mem_reg_write_q;
  logic [REG_ADDR_W-1:0] ex_mem_rd_d, ex_mem_rd_q;
  logic                  mem_wb_reg_write_d, mem_wb_reg_write_q;
  logic                  mem_wb_mem_to_reg_d, mem_wb_mem_to_reg_q;
  logic [REG_ADDR_W-1:0] mem_wb_rd_d, mem_wb_rd_q;

  // Decode the ID opcode into a control word and its source-register usage.
  always_comb begin
    dec      = '0;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (idOpcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = ALUOP_W'(2);
        uses_rs2      = 1'b1;
      end
      OP_IALU: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALUOP_W'(3);
      end
      OP_LOAD: begin
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
      end
      OP_STORE: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        uses_rs2      = 1'b1;
      end
      OP_BRANCH: begin
        dec.branch = 1'b1;
        dec.alu_op = ALUOP_W'(1);
        uses_rs2   = 1'b1;
      end
      OP_JAL: begin
        uses_rs1 = 1'b0;
        if (JUMP_EN) begin
          dec.jump      = 2'b01;
          dec.reg_write = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_JALR: begin
        if (JUMP_EN) begin
          dec.jump      = 2'b10;
          dec.alu_src   = 1'b1;
          dec.reg_write = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_BUBBLE: begin
        uses_rs1 = 1'b0;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
    // Bubbles and undecodable opcodes carry no destination; x0 is never written.
    if (!dec.illegal && (idOpcode != OP_BUBBLE)) dec.rd = idRd;
    if (idRd == '0) dec.reg_write = 1'b0;
  end

  // Load-use hazard: a load in EX targets a register the ID instruction reads.
  always_comb begin
    load_use = id_ex_q.mem_read && (id_ex_q.rd != '0) &&
               ((uses_rs1 && (id_ex_q.rd == idRs1)) ||
                (uses_rs2 && (id_ex_q.rd == idRs2)));
  end

  // Front-end enables: hold freezes everything, flush redirects, load-use stalls.
  always_comb begin
    pcWrite   = 1'b0;
    ifidWrite = 1'b0;
    ifidFlush = 1'b0;
    if (reset && !hold) begin
      if (flush) begin
        pcWrite   = 1'b1;
        ifidWrite = 1'b1;
        ifidFlush = 1'b1;
      end else if (!load_use) begin
        pcWrite   = 1'b1;
        ifidWrite = 1'b1;
      end
    end
  end

  // Next-state for the stage registers: keep on hold, bubble ID/EX on flush or stall.
  always_comb begin
    id_ex_d             = id_ex_q;
    ex_mem_read_d       = ex_mem_read_q;
    ex_mem_write_d      = ex_mem_write_q;
    ex_mem_to_reg_d     = ex_mem_to_reg_q;
    ex_mem_reg_write_d  = ex_mem_reg_write_q;
    ex_mem_rd_d         = ex_mem_rd_q;
    mem_wb_reg_write_d  = mem_wb_reg_write_q;
    mem_wb_mem_to_reg_d = mem_wb_mem_to_reg_q;
    mem_wb_rd_d         = mem_wb_rd_q;
    if (!hold) begin
      id_ex_d             = (flush || load_use) ? '0 : dec;
      ex_mem_read_d       = id_ex_q.mem_read;
      ex_mem_write_d      = id_ex_q.mem_write;
      ex_mem_to_reg_d     = id_ex_q.mem_to_reg;
      ex_mem_reg_write_d  = id_ex_q.reg_write;
      ex_mem_rd_d         = id_ex_q.rd;
      mem_wb_reg_write_d  = ex_mem_reg_write_q;
      mem_wb_mem_to_reg_d = ex_mem_to_reg_q;
      mem_wb_rd_d         = ex_mem_rd_q;
    end
  end

  // Stage registers; reset clears every stage to a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_ex_q             <= '0;
      ex_mem_read_q       <= 1'b0;
      ex_mem_write_q      <= 1'b0;
      ex_mem_to_reg_q     <= 1'b0;
      ex_mem_reg_write_q  <= 1'b0;
      ex_mem_rd_q         <= '0;
      mem_wb_reg_write_q  <= 1'b0;
      mem_wb_mem_to_reg_q <= 1'b0;
      mem_wb_rd_q         <= '0;
    end else begin
      id_ex_q             <= id_ex_d;
      ex_mem_read_q       <= ex_mem_read_d;
      ex_mem_write_q      <= ex_mem_write_d;
      ex_mem_to_reg_q     <= ex_mem_to_reg_d;
      ex_mem_reg_write_q  <= ex_mem_reg_write_d;
      ex_mem_rd_q         <= ex_mem_rd_d;
      mem_wb_reg_write_q  <= mem_wb_reg_write_d;
      mem_wb_mem_to_reg_q <= mem_wb_mem_to_reg_d;
      mem_wb_rd_q         <= mem_wb_rd_d;
    end
  end

  assign exALUop     = id_ex_q.alu_op;
  assign exALUsrc    = id_ex_q.alu_src;
  assign exBranch    = id_ex_q.branch;
  assign exJump      = JUMP_EN ? id_ex_q.jump : 2'b00;
  assign exMemRead   = id_ex_q.mem_read;
  assign exRd        = id_ex_q.rd;
  assign exIllegal   = id_ex_q.illegal;
  assign memMemRead  = ex_mem_read_q;
  assign memMemWrite = ex_mem_write_q;
  assign memRd       = ex_mem_rd_q;
  assign wbRegWrite  = mem_wb_reg_write_q;
  assign wbMemtoReg  = mem_wb_mem_to_reg_q;
  assign wbRd        = mem_wb_rd_q;

endmodule
